// File: rtl/prog_sequencer.sv
// Run controller for the single-cycle core: loads the selected program's start
// address, enables the core until HALT/abort/timeout, and reports completion status.
module prog_sequencer #(
  parameter int PC_W    = 8,
  parameter int START0  = 0,
  parameter int START1  = 25,
  parameter int START2  = 44,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_req,
  input  logic [1:0]       prog_sel,
  input  logic             abort,
  input  logic             halt,
  output logic             start_ack,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             aborted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       last_prog,
  output logic             err_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int STARTS [4] = '{START0, START1, START2, 0};
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state;
  logic [PC_W-1:0]  start_addr [4];
  logic [CNT_W-1:0] count_inc;
  logic             limit_hit;

  // Index 3 is never latched into last_prog; its entry only keeps the table total.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_start
      assign start_addr[gi] = PC_W'(STARTS[gi]);
    end
  endgenerate

  assign count_inc = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
  assign limit_hit = (count_inc >= TIMEOUT_C);

  always_comb begin
    pc_load_val = '0;
    if (state == LOAD)
      pc_load_val = start_addr[last_prog];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      start_ack   <= 1'b0;
      pc_load     <= 1'b0;
      core_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      aborted     <= 1'b0;
      cycle_count <= '0;
      last_prog   <= 2'd0;
      err_sel     <= 1'b0;
    end else begin
      start_ack <= 1'b0;
      pc_load   <= 1'b0;
      done      <= 1'b0;
      err_sel   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            if (prog_sel != 2'd3) begin
              start_ack   <= 1'b1;
              pc_load     <= 1'b1;
              busy        <= 1'b1;
              last_prog   <= prog_sel;
              cycle_count <= '0;
              timed_out   <= 1'b0;
              aborted     <= 1'b0;
              state       <= LOAD;
            end else begin
              err_sel <= 1'b1;
            end
          end
        end
        LOAD: begin
          core_en <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          cycle_count <= count_inc;
          // The exiting cycle itself is counted; halt masks both status flags.
          if (halt || abort || limit_hit) begin
            core_en   <= 1'b0;
            done      <= 1'b1;
            aborted   <= !halt && abort;
            timed_out <= !halt && !abort;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a driver issues runs and queues the
// expected acks/completions, a negedge monitor pops and compares them.
module tb_prog_sequencer;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam int TO    = 20;
  localparam int ST [3] = '{0, 25, 44};

  logic             clk;
  logic             reset;
  logic             start_req;
  logic [1:0]       prog_sel;
  logic             abort;
  logic             halt;
  logic             start_ack;
  logic             pc_load;
  logic [PC_W-1:0]  pc_load_val;
  logic             core_en;
  logic             busy;
  logic             done;
  logic             timed_out;
  logic             aborted;
  logic [CNT_W-1:0] cycle_count;
  logic [1:0]       last_prog;
  logic             err_sel;

  prog_sequencer #(
    .PC_W(PC_W), .START0(0), .START1(25), .START2(44), .CNT_W(CNT_W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .prog_sel(prog_sel),
    .abort(abort), .halt(halt), .start_ack(start_ack), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .core_en(core_en), .busy(busy), .done(done),
    .timed_out(timed_out), .aborted(aborted), .cycle_count(cycle_count),
    .last_prog(last_prog), .err_sel(err_sel)
  );

  typedef struct {
    int prog;
    int cyc;
  } ack_t;

  typedef struct {
    int prog;
    int cyc;
    int cycles;
    int to;
    int ab;
  } done_t;

  ack_t  ack_q [$];
  done_t done_q [$];
  int    err_q [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  bit after_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every presented DUT event against the scoreboard queues.
  initial begin
    ack_t  a;
    done_t d;
    int    e;
    forever begin
      @(negedge clk);
      if (reset) begin
        en_cnt = 0;
        after_done = 0;
      end else begin
        if (after_done) chk("busy_after_done", busy, 0);
        after_done = 0;
        if (core_en) en_cnt++;
        if (start_ack) begin
          if (ack_q.size() == 0) unexpected("ack");
          else begin
            a = ack_q.pop_front();
            chk("ack_cycle", cyc, a.cyc);
            chk("ack_last_prog", last_prog, a.prog);
            chk("ack_pc_load", pc_load, 1);
            chk("ack_pc_load_val", pc_load_val, ST[a.prog]);
            chk("ack_count_clear", cycle_count, 0);
            chk("ack_flags_clear", {timed_out, aborted}, 0);
            chk("ack_busy", busy, 1);
            chk("ack_core_en", core_en, 0);
            $display("ack  prog=%0d pc_load_val=%0d cycle=%0d", a.prog, pc_load_val, cyc);
          end
          en_cnt = 0;
        end
        if (done) begin
          if (done_q.size() == 0) unexpected("done");
          else begin
            d = done_q.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("done_cycle_count", cycle_count, d.cycles);
            chk("done_core_en_cycles", en_cnt, d.cycles);
            chk("done_timed_out", timed_out, d.to);
            chk("done_aborted", aborted, d.ab);
            chk("done_last_prog", last_prog, d.prog);
            chk("done_core_en_low", core_en, 0);
            chk("done_pc_load_val_zero", pc_load_val, 0);
            $display("done prog=%0d count=%0d timed_out=%0d aborted=%0d", d.prog, cycle_count,
                     timed_out, aborted);
          end
          after_done = 1;
        end
        if (err_sel) begin
          if (err_q.size() == 0) unexpected("err_sel");
          else begin
            e = err_q.pop_front();
            chk("err_cycle", cyc, e);
            chk("err_no_ack", start_ack, 0);
            chk("err_busy", busy, 0);
            $display("err  rejected prog_sel=3 cycle=%0d", cyc);
          end
        end
      end
    end
  end

  task automatic idle_gap(input int n);
    repeat (n) begin
      halt  = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    halt  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic err_req();
    start_req = 1'b1;
    prog_sel  = 2'd3;
    err_q.push_back(cyc + 1);
    @(negedge clk);
    start_req = 1'b0;
  endtask

  // Called at a negedge while the DUT is idle; h/a are 1-based RUN cycles (0 = never).
  task automatic do_run(input int sel, input int h, input int a, input int rst_at,
                        input bit chain, input int next_sel);
    ack_t  ea;
    done_t ed;
    int    r_end;
    r_end = TO;
    if (h > 0 && h < r_end) r_end = h;
    if (a > 0 && a < r_end) r_end = a;
    ed.prog = sel;
    ed.cyc = cyc + 2 + r_end;
    ed.cycles = r_end;
    ed.to = 0;
    ed.ab = 0;
    if (h != r_end) begin
      if (a == r_end) ed.ab = 1;
      else ed.to = 1;
    end
    ea.prog = sel;
    ea.cyc = cyc + 1;
    ack_q.push_back(ea);
    if (rst_at == 0) done_q.push_back(ed);
    start_req = 1'b1;
    prog_sel  = 2'(sel);
    halt      = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    start_req = 1'($urandom_range(0, 1));
    prog_sel  = 2'($urandom_range(0, 3));
    halt      = 1'($urandom_range(0, 1));
    abort     = 1'($urandom_range(0, 1));
    for (int c = 1; c <= r_end; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_core_en", core_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_last_prog", last_prog, 0);
        chk("rst_pulses", {start_ack, pc_load, done, err_sel}, 0);
        chk("rst_flags", {timed_out, aborted}, 0);
        $display("rst  asserted on RUN cycle %0d", c);
        start_req = 1'b0;
        halt = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      halt      = (c == h);
      abort     = (c == a);
      start_req = 1'($urandom_range(0, 1));
      prog_sel  = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    halt      = 1'($urandom_range(0, 1));
    abort     = 1'($urandom_range(0, 1));
    start_req = chain;
    prog_sel  = chain ? 2'(next_sel) : 2'd0;
    @(negedge clk);
    halt  = 1'b0;
    abort = 1'b0;
    if (!chain) start_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int nxt;
    int h;
    int a;
    bit chain;
    reset = 1'b1;
    start_req = 1'b0;
    prog_sel = 2'd0;
    abort = 1'b0;
    halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {start_ack, pc_load, core_en, busy, done, timed_out, aborted, err_sel}, 0);
    chk("reset_count", cycle_count, 0);
    chk("reset_last_prog", last_prog, 0);
    chk("reset_pc_load_val", pc_load_val, 0);
    reset = 1'b0;
    @(negedge clk);

    do_run(1, 10, 0, 0, 0, 0);
    idle_gap(2);
    do_run(0, 3, 0, 0, 1, 1);
    do_run(1, 4, 0, 0, 1, 2);
    do_run(2, 5, 0, 0, 0, 0);
    idle_gap(2);
    do_run(0, 0, 0, 0, 0, 0);
    do_run(2, 6, 0, 0, 0, 0);
    err_req();
    idle_gap(2);
    do_run(1, 7, 7, 0, 0, 0);
    do_run(2, 0, 5, 0, 0, 0);
    do_run(0, TO, 0, 0, 0, 0);
    do_run(1, 0, TO, 0, 0, 0);
    do_run(1, 12, 0, 3, 0, 0);
    do_run(2, 6, 0, 0, 0, 0);

    sel = $urandom_range(0, 2);
    for (int i = 0; i < 40; i++) begin
      nxt   = $urandom_range(0, 2);
      chain = (i != 39) && ($urandom_range(0, 2) == 0);
      h = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 25);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : 0;
      do_run(sel, h, a, 0, chain, nxt);
      if (!chain) begin
        if ($urandom_range(0, 3) == 0) err_req();
        idle_gap($urandom_range(0, 3));
      end
      sel = nxt;
    end

    idle_gap(5);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
